// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder assembled from two half-adder stages and an OR.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic h1_s;
    logic h1_c;
    logic h2_c;

    assign h1_s = x ^ y;
    assign h1_c = x & y;
    assign s    = h1_s ^ cin;
    assign h2_c = h1_s & cin;
    assign cout = h1_c | h2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through a single fa_cell.
// Optional feature macro SERADD_SUB_EN enables subtraction via the sub input.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             fa_s;
    logic             fa_cout;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERADD_SUB_EN
    // Subtract as A + ~B + 1: invert B and seed the carry with 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign c_load     = 1'b0;
`endif

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    fa_cell u_fa (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            result    <= '0;
            cnt       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b_load;
            cnt  <= '0;
            c    <= c_load;
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            c      <= fa_cout;
            result <= {fa_s, result[WIDTH-1:1]};
            // Publish on the final bit so sum holds steady while the next op runs.
            if (last) begin
                sum       <= {fa_s, result[WIDTH-1:1]};
                carry_out <= fa_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         sub_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int tests = 0;
    int fails = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a_in),
        .b         (b_in),
        .sub       (sub_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
`ifdef SERADD_SUB_EN
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`endif
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Drive a one-cycle start; returns at the negedge after the accepting edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        start  = 1'b1;
        a_in   = x;
        b_in   = y;
        sub_in = s;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called n0 negedges after acceptance; returns at the negedge where done is high.
    task automatic wait_result(input string tag, input int n0, input logic [W:0] exp);
        int n = n0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 9);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[W-1:0]});
        check({tag, "_cout"}, {31'd0, carry_out}, {31'd0, exp[W]});
    endtask

    task automatic after_done(input string tag, input logic [W:0] exp);
        @(negedge clk);
        check({tag, "_pulse_end"}, {31'd0, done}, 32'd0);
        check({tag, "_hold_sum"}, {24'd0, sum}, {24'd0, exp[W-1:0]});
        check({tag, "_hold_cout"}, {31'd0, carry_out}, {31'd0, exp[W]});
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic         s;
        logic [W:0]   exp;

        // Reset state and idle behaviour
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {busy, done, carry_out, sum}, 32'd0);
        end

        // Basic add
        launch(8'h03, 8'h05, 1'b0);
        wait_result("add_3_5", 1, 9'h008);
        after_done("add_3_5", 9'h008);

        // Overflow, then back-to-back start in the DONE cycle
        launch(8'hFF, 8'h01, 1'b0);
        wait_result("ovf", 1, 9'h100);
        launch(8'h10, 8'h20, 1'b0);
        wait_result("b2b", 1, 9'h030);
        after_done("b2b", 9'h030);

        // Start during RUN is ignored
        launch(8'h0A, 8'h0B, 1'b0);
        repeat (2) @(negedge clk);
        launch(8'hFF, 8'hFF, 1'b0);
        wait_result("ignore", 4, 9'h015);
        after_done("ignore", 9'h015);
        repeat (3) @(negedge clk);
        check("not_queued", {30'd0, busy, done}, 32'd0);

        // Reset during RUN
        launch(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out", {busy, done, carry_out, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midrst_quiet", {busy, done, carry_out, sum}, 32'd0);
        end
        launch(8'hAA, 8'h55, 1'b0);
        wait_result("post_rst", 1, 9'h0FF);
        after_done("post_rst", 9'h0FF);

`ifdef SERADD_SUB_EN
        launch(8'd5, 8'd3, 1'b1);
        wait_result("sub_5_3", 1, 9'h102);
        after_done("sub_5_3", 9'h102);
        launch(8'd3, 8'd5, 1'b1);
        wait_result("sub_3_5", 1, 9'h0FE);
        after_done("sub_3_5", 9'h0FE);
`endif

        // Randomized operations, sub toggled to cover both builds
        for (int i = 0; i < 40; i++) begin
            x   = W'($urandom);
            y   = W'($urandom);
            s   = 1'($urandom_range(0, 1));
            exp = model(x, y, s);
            launch(x, y, s);
            wait_result("rand", 1, exp);
            if ($urandom_range(0, 1) == 0) begin
                after_done("rand", exp);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
